// File: rtl/board_generator_pkg.sv
// Shared constants and FSM encoding for the shuffled-board generator.
// Boards are nine 2-bit symbols packed row-major, slot 0 in the top bits.
package board_generator_pkg;

   localparam int SYM_W     = 2;
   localparam int NUM_SLOTS = 9;
   localparam int BOARD_W   = 18;
   localparam int IDX_W     = 4;

   localparam logic [15:0]        LFSR_RESET    = 16'hACE1;
   localparam logic [BOARD_W-1:0] SORTED_BOARD  = 18'h0056A;
   localparam logic [BOARD_W-1:0] DEFAULT_BOARD = 18'h0245A;
   localparam int                 MAX_REJECTS   = 5;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      PICK = 3'd2,
      SWAP = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11. A zero seed would lock the
// register up, so it is replaced with the reset value on load.
module lfsr16
   import board_generator_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q <= LFSR_RESET;
      end else if (load) begin
         q <= (seed == 16'h0000) ? LFSR_RESET : seed;
      end else begin
         q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
      end
   end

endmodule

// File: rtl/board_generator.sv
// Produces a board holding each of three symbols exactly three times, using a
// Fisher-Yates shuffle driven by a free-running LFSR with bounded rejection.
module board_generator
   import board_generator_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               seed_we,
   input  logic [15:0]        seed,
   output logic [BOARD_W-1:0] board,
   output logic               board_valid,
   output logic               busy,
   output logic               done
);

   state_t             state;
   state_t             state_next;
   logic [15:0]        lfsr;
   logic               lfsr_load;
   logic [BOARD_W-1:0] work;
   logic [BOARD_W-1:0] swapped;
   logic [IDX_W-1:0]   idx_i;
   logic [IDX_W-1:0]   idx_j;
   logic [IDX_W-1:0]   cand;
   logic [2:0]         rej_cnt;
   logic               accept;
   logic               force_pick;
   logic [SYM_W-1:0]   sym_i;
   logic [SYM_W-1:0]   sym_j;

   assign lfsr_load  = (state == IDLE) && seed_we;
   assign cand       = lfsr[IDX_W-1:0];
   assign accept     = (cand <= idx_i);
   assign force_pick = !accept && (rej_cnt == 3'(MAX_REJECTS - 1));

   lfsr16 u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (lfsr_load),
      .seed    (seed),
      .q       (lfsr)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      done       = (state == DONE);
      case (state)
         IDLE:    if (start) state_next = INIT;
         INIT:    state_next = PICK;
         PICK:    if (accept || force_pick) state_next = SWAP;
         SWAP:    state_next = (idx_i == 4'd1) ? DONE : PICK;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Exchange slots i and j of the work register; j == i leaves it unchanged.
   always_comb begin
      sym_i   = '0;
      sym_j   = '0;
      swapped = work;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (4'(k) == idx_i) sym_i = work[BOARD_W-1-SYM_W*k -: SYM_W];
         if (4'(k) == idx_j) sym_j = work[BOARD_W-1-SYM_W*k -: SYM_W];
      end
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (4'(k) == idx_i) begin
            swapped[BOARD_W-1-SYM_W*k -: SYM_W] = sym_j;
         end else if (4'(k) == idx_j) begin
            swapped[BOARD_W-1-SYM_W*k -: SYM_W] = sym_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         board       <= DEFAULT_BOARD;
         board_valid <= 1'b0;
         work        <= SORTED_BOARD;
         idx_i       <= '0;
         idx_j       <= '0;
         rej_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) board_valid <= 1'b0;
            end
            INIT: begin
               work    <= SORTED_BOARD;
               idx_i   <= 4'd8;
               rej_cnt <= '0;
            end
            PICK: begin
               if (accept) begin
                  idx_j <= cand;
               end else begin
                  rej_cnt <= rej_cnt + 3'd1;
                  if (force_pick) idx_j <= idx_i;
               end
            end
            SWAP: begin
               work    <= swapped;
               rej_cnt <= '0;
               if (idx_i != 4'd1) idx_i <= idx_i - 4'd1;
            end
            DONE: begin
               board       <= work;
               board_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_board_generator.sv
// Self-checking bench for board_generator: directed table plus randomized soak,
// compared against a cycle-counting Fisher-Yates reference model.
module tb_board_generator;
   import board_generator_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        seed_we = 1'b0;
   logic [15:0] seed = 16'h0000;
   logic [17:0] board;
   logic        board_valid;
   logic        busy;
   logic        done;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_lfsr;
   logic [17:0] prev_board;
   logic        m_valid;

   typedef struct {
      bit          do_seed;
      logic [15:0] seed;
      int          gap;
      int          inject_at;
      int          min_lat;
      int          max_lat;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   board_generator dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .seed_we     (seed_we),
      .seed        (seed),
      .board       (board),
      .board_valid (board_valid),
      .busy        (busy),
      .done        (done)
   );

   function automatic logic [15:0] lfsrStep(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic logic [15:0] seedFix(input logic [15:0] s);
      return (s == 16'h0000) ? 16'hACE1 : s;
   endfunction

   // l0 is the LFSR value during INIT; lat counts cycles from the start cycle to DONE.
   task automatic modelShuffle(input logic [15:0] l0, output logic [17:0] b,
                               output int lat, output logic [15:0] lend);
      int          sym[9];
      int          j;
      int          rej;
      int          tmp;
      logic [15:0] l;
      sym = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
      l   = lfsrStep(l0);
      lat = 1;
      for (int i = 8; i >= 1; i--) begin
         rej = 0;
         forever begin
            j   = int'(l[3:0]);
            l   = lfsrStep(l);
            lat = lat + 1;
            if (j <= i) break;
            rej = rej + 1;
            if (rej == MAX_REJECTS) begin
               j = i;
               break;
            end
         end
         tmp    = sym[i];
         sym[i] = sym[j];
         sym[j] = tmp;
         l      = lfsrStep(l);
         lat    = lat + 1;
      end
      lat = lat + 1;
      l   = lfsrStep(l);
      b   = '0;
      for (int k = 0; k < 9; k++) b = {b[15:0], 2'(sym[k])};
      lend = l;
   endtask

   function automatic bit histogramOk(input logic [17:0] b);
      int          cnt[4];
      logic [17:0] t;
      cnt = '{0, 0, 0, 0};
      t   = b;
      for (int k = 0; k < 9; k++) begin
         cnt[t[17:16]]++;
         t = t << 2;
      end
      return (cnt[0] == 3) && (cnt[1] == 3) && (cnt[2] == 3) && (cnt[3] == 0);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n, input bit rand_seed);
      for (int c = 0; c < n; c++) begin
         if (rand_seed && ($urandom_range(0, 3) == 0)) begin
            seed_we = 1'b1;
            seed    = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
         end
         tick();
         m_lfsr  = seed_we ? seedFix(seed) : lfsrStep(m_lfsr);
         seed_we = 1'b0;
         checkOutput("idle_busy", 32'(busy), 32'd0);
         checkOutput("idle_done", 32'(done), 32'd0);
         checkOutput("idle_valid", 32'(board_valid), 32'(m_valid));
         checkOutput("idle_board", 32'(board), 32'(prev_board));
         checkOutput("idle_lfsr", 32'(dut.u_lfsr.q), 32'(m_lfsr));
      end
   endtask

   task automatic applyStimulus(input bit do_seed, input logic [15:0] sv, input int inject_at,
                                input int min_lat, input int max_lat);
      logic [15:0] l_after;
      logic [15:0] l_end;
      logic [17:0] exp_b;
      int          exp_lat;
      int          cyc;
      l_after = do_seed ? seedFix(sv) : lfsrStep(m_lfsr);
      modelShuffle(l_after, exp_b, exp_lat, l_end);
      start   = 1'b1;
      seed_we = do_seed;
      seed    = sv;
      tick();
      start   = 1'b0;
      seed_we = 1'b0;
      checkOutput("valid_clear", 32'(board_valid), 32'd0);
      cyc = 1;
      while (!done && cyc < 60) begin
         checkOutput("busy_hold", 32'(busy), 32'd1);
         checkOutput("board_stable", 32'(board), 32'(prev_board));
         if (cyc == inject_at) begin
            start   = 1'b1;
            seed_we = 1'b1;
            seed    = 16'($urandom);
         end
         tick();
         start   = 1'b0;
         seed_we = 1'b0;
         cyc++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected %0d", cyc, exp_lat);
      end else begin
         checkOutput("latency", 32'(cyc), 32'(exp_lat));
         checkOutput("latency_range", 32'((cyc >= min_lat) && (cyc <= max_lat)), 32'd1);
         checkOutput("busy_in_done", 32'(busy), 32'd1);
      end
      tick();
      m_valid    = 1'b1;
      prev_board = exp_b;
      m_lfsr     = l_end;
      checkOutput("done_single", 32'(done), 32'd0);
      checkOutput("busy_after", 32'(busy), 32'd0);
      checkOutput("valid_set", 32'(board_valid), 32'd1);
      checkOutput("board", 32'(board), 32'(exp_b));
      checkOutput("histogram", 32'(histogramOk(board)), 32'd1);
      checkOutput("lfsr_after", 32'(dut.u_lfsr.q), 32'(m_lfsr));
   endtask

   task automatic resetDut();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n    = 1'b1;
      m_lfsr     = LFSR_RESET;
      prev_board = DEFAULT_BOARD;
      m_valid    = 1'b0;
   endtask

   initial begin
      vecs[0] = '{do_seed: 1'b1, seed: 16'h1234, gap: 1, inject_at: -1, min_lat: 18, max_lat: 50};
      vecs[1] = '{do_seed: 1'b1, seed: 16'h0000, gap: 2, inject_at: -1, min_lat: 18, max_lat: 50};
      vecs[2] = '{do_seed: 1'b1, seed: 16'hACE1, gap: 0, inject_at: -1, min_lat: 18, max_lat: 50};
      vecs[3] = '{do_seed: 1'b1, seed: 16'hBEEF, gap: 3, inject_at: 5,  min_lat: 18, max_lat: 50};
      vecs[4] = '{do_seed: 1'b0, seed: 16'h5555, gap: 4, inject_at: 7,  min_lat: 18, max_lat: 50};
      vecs[5] = '{do_seed: 1'b1, seed: 16'h0001, gap: 1, inject_at: -1, min_lat: 18, max_lat: 50};

      // Reset state, sampled while reset is still asserted.
      reset_n = 1'b0;
      tick();
      tick();
      checkOutput("rst_board", 32'(board), 32'(DEFAULT_BOARD));
      checkOutput("rst_valid", 32'(board_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_lfsr", 32'(dut.u_lfsr.q), 32'(LFSR_RESET));
      resetDut();

      foreach (vecs[v]) begin
         idleCycles(vecs[v].gap, 1'b0);
         applyStimulus(vecs[v].do_seed, vecs[v].seed, vecs[v].inject_at,
                       vecs[v].min_lat, vecs[v].max_lat);
      end
      idleCycles(3, 1'b0);

      // Reset in cycle 10 of a generation must discard the partial board.
      start   = 1'b1;
      seed_we = 1'b1;
      seed    = 16'h2468;
      tick();
      start   = 1'b0;
      seed_we = 1'b0;
      for (int c = 1; c < 10; c++) begin
         checkOutput("mid_no_done", 32'(done), 32'd0);
         tick();
      end
      reset_n = 1'b0;
      tick();
      checkOutput("mid_rst_board", 32'(board), 32'(DEFAULT_BOARD));
      checkOutput("mid_rst_valid", 32'(board_valid), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_done", 32'(done), 32'd0);
      reset_n    = 1'b1;
      m_lfsr     = LFSR_RESET;
      prev_board = DEFAULT_BOARD;
      m_valid    = 1'b0;
      idleCycles(2, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         idleCycles(int'($urandom_range(0, 3)), 1'b1);
         applyStimulus(bit'($urandom_range(0, 1)), 16'($urandom),
                       ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 15)) : -1,
                       18, 50);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
